// File: rtl/gb_eq_pkg.sv
// rtl/gb_eq_pkg.sv - shared types and constants for the Gaussian-blur execution scheduler
package gb_eq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_RESP,
    ST_RUN,
    ST_FIN
  } sched_state_e;

  localparam logic [31:0] AP_START      = 32'h1;
  localparam logic [4:0]  CTRL_ADDR_DEF = 5'h00;
  localparam logic [1:0]  BRESP_OKAY    = 2'b00;

endpackage

// File: rtl/axil_single_write.sv
// rtl/axil_single_write.sv - one-beat AXI-Lite write master with independent AW/W handshakes
module axil_single_write
  import gb_eq_pkg::*;
#(
  parameter int                 ADDR_W = 5,
  parameter int                 DATA_W = 32,
  parameter logic [ADDR_W-1:0]  ADDR   = '0,
  parameter logic [DATA_W-1:0]  DATA   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  awready_i,
  input  logic                  wready_i,
  input  logic                  bvalid_i,
  input  logic [1:0]            bresp_i,
  output logic                  awvalid_o,
  output logic [ADDR_W-1:0]     awaddr_o,
  output logic                  wvalid_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic                  bready_o,
  output logic                  busy_o,
  output logic                  addr_done_o,
  output logic                  ok_o,
  output logic                  err_o
);

  logic aw_pend_q, aw_pend_d;
  logic w_pend_q, w_pend_d;
  logic resp_q, resp_d;
  logic aw_hs, w_hs, b_hs;

  assign aw_hs = aw_pend_q & awready_i;
  assign w_hs  = w_pend_q & wready_i;
  assign b_hs  = resp_q & bvalid_i;

  // Address phase completes when every still-pending channel handshakes this cycle.
  assign addr_done_o = (aw_pend_q | w_pend_q) & (~aw_pend_q | awready_i) & (~w_pend_q | wready_i);

  assign awvalid_o = aw_pend_q;
  assign wvalid_o  = w_pend_q;
  assign bready_o  = resp_q;
  assign awaddr_o  = ADDR;
  assign wdata_o   = DATA;
  assign wstrb_o   = '1;
  assign busy_o    = aw_pend_q | w_pend_q | resp_q;
  assign ok_o      = b_hs & (bresp_i == BRESP_OKAY);
  assign err_o     = b_hs & (bresp_i != BRESP_OKAY);

  always_comb begin
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    resp_d    = resp_q;
    if (abort_i) begin
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
      resp_d    = 1'b0;
    end else if (start_i) begin
      aw_pend_d = 1'b1;
      w_pend_d  = 1'b1;
      resp_d    = 1'b0;
    end else begin
      if (aw_hs)       aw_pend_d = 1'b0;
      if (w_hs)        w_pend_d  = 1'b0;
      if (addr_done_o) resp_d    = 1'b1;
      if (b_hs)        resp_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      resp_q    <= resp_d;
    end
  end

endmodule

// File: rtl/gb_exec_sched.sv
// rtl/gb_exec_sched.sv - per-instruction scheduler: ap_start write, step gating, HLS drain and watchdog
module gb_exec_sched
  import gb_eq_pkg::*;
#(
  parameter int                    CFG_ADDR_W = 5,
  parameter int                    CFG_DATA_W = 32,
  parameter logic [CFG_ADDR_W-1:0] CTRL_ADDR  = CFG_ADDR_W'(CTRL_ADDR_DEF),
  parameter int                    DRAIN      = 6,
  parameter int                    TMO_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    exec_valid,
  output logic                    exec_ready,
  output logic                    done,
  output logic                    timeout,
  output logic                    cfg_err,
  input  logic                    ila_complete,
  input  logic                    hls_complete,
  output logic                    ila_step,
  output logic                    hls_step,
  output logic                    s_axi_config_AWVALID,
  input  logic                    s_axi_config_AWREADY,
  output logic [CFG_ADDR_W-1:0]   s_axi_config_AWADDR,
  output logic                    s_axi_config_WVALID,
  input  logic                    s_axi_config_WREADY,
  output logic [CFG_DATA_W-1:0]   s_axi_config_WDATA,
  output logic [CFG_DATA_W/8-1:0] s_axi_config_WSTRB,
  input  logic                    s_axi_config_BVALID,
  output logic                    s_axi_config_BREADY,
  input  logic [1:0]              s_axi_config_BRESP
);

  localparam int             DW        = $clog2(DRAIN + 1);
  localparam logic [DW-1:0]  DRAIN_CNT = DW'(DRAIN);

  sched_state_e     state_q, state_d;
  logic             ila_fin_q, ila_fin_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             wr_start, wr_abort, wr_busy, wr_addr_done, wr_ok, wr_err;
  logic             active;

  axil_single_write #(
    .ADDR_W (CFG_ADDR_W),
    .DATA_W (CFG_DATA_W),
    .ADDR   (CTRL_ADDR),
    .DATA   (CFG_DATA_W'(AP_START))
  ) u_wr (
    .clk         (clk),
    .rst         (rst),
    .start_i     (wr_start),
    .abort_i     (wr_abort),
    .awready_i   (s_axi_config_AWREADY),
    .wready_i    (s_axi_config_WREADY),
    .bvalid_i    (s_axi_config_BVALID),
    .bresp_i     (s_axi_config_BRESP),
    .awvalid_o   (s_axi_config_AWVALID),
    .awaddr_o    (s_axi_config_AWADDR),
    .wvalid_o    (s_axi_config_WVALID),
    .wdata_o     (s_axi_config_WDATA),
    .wstrb_o     (s_axi_config_WSTRB),
    .bready_o    (s_axi_config_BREADY),
    .busy_o      (wr_busy),
    .addr_done_o (wr_addr_done),
    .ok_o        (wr_ok),
    .err_o       (wr_err)
  );

  assign active = (state_q == ST_CFG) | (state_q == ST_RESP) | (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    ila_fin_d  = ila_fin_q;
    drain_d    = drain_q;
    tmo_d      = tmo_q;
    exec_ready = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    cfg_err    = 1'b0;
    ila_step   = 1'b0;
    hls_step   = 1'b0;
    wr_start   = 1'b0;
    wr_abort   = 1'b0;
    if (active) tmo_d = tmo_q + TMO_W'(1);
    case (state_q)
      ST_IDLE: begin
        exec_ready = ~wr_busy;
        if (exec_valid && !wr_busy) begin
          state_d   = ST_CFG;
          ila_fin_d = 1'b0;
          drain_d   = '0;
          tmo_d     = '0;
          wr_start  = 1'b1;
        end
      end
      ST_CFG: begin
        if (wr_addr_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (wr_ok) begin
          state_d = ST_RUN;
        end else if (wr_err) begin
          cfg_err = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        ila_step = ~ila_fin_q & ~ila_complete;
        hls_step = drain_q < DRAIN_CNT;
        if (ila_complete) ila_fin_d = 1'b1;
        // Any drop of hls_complete restarts the drain window from zero.
        if (hls_complete) begin
          if (drain_q < DRAIN_CNT) drain_d = drain_q + DW'(1);
        end else begin
          drain_d = '0;
        end
        if (ila_fin_q && drain_q == DRAIN_CNT) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Watchdog overrides any other outcome of this cycle.
    if (active && tmo_q == {TMO_W{1'b1}}) begin
      timeout  = 1'b1;
      cfg_err  = 1'b0;
      wr_abort = 1'b1;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ila_fin_q <= 1'b0;
      drain_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      ila_fin_q <= ila_fin_d;
      drain_q   <= drain_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_gb_exec_sched.sv
// tb/tb_gb_exec_sched.sv - randomized and directed self-checking bench for gb_exec_sched
module tb_gb_exec_sched;

  localparam int DRAIN   = 6;
  localparam int TMO_W   = 6;
  localparam int TMO_CYC = 1 << TMO_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        exec_valid, exec_ready, done, timeout, cfg_err;
  logic        ila_complete, hls_complete, ila_step, hls_step;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [4:0]  awaddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;

  int total = 0;
  int bad   = 0;

  gb_exec_sched #(.DRAIN(DRAIN), .TMO_W(TMO_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .exec_valid           (exec_valid),
    .exec_ready           (exec_ready),
    .done                 (done),
    .timeout              (timeout),
    .cfg_err              (cfg_err),
    .ila_complete         (ila_complete),
    .hls_complete         (hls_complete),
    .ila_step             (ila_step),
    .hls_step             (hls_step),
    .s_axi_config_AWVALID (awvalid),
    .s_axi_config_AWREADY (awready),
    .s_axi_config_AWADDR  (awaddr),
    .s_axi_config_WVALID  (wvalid),
    .s_axi_config_WREADY  (wready),
    .s_axi_config_WDATA   (wdata),
    .s_axi_config_WSTRB   (wstrb),
    .s_axi_config_BVALID  (bvalid),
    .s_axi_config_BREADY  (bready),
    .s_axi_config_BRESP   (bresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    exec_valid = 0; awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    ila_complete = 0; hls_complete = 0;
  endtask

  // Offsets ila_off/h_off are relative to the cycle RUN is expected to start.
  task automatic run_txn(input string name, input int aw_at, input int w_at, input int b_at,
                         input logic [1:0] br, input int ila_off, input int h_off,
                         input bit glitch, input bit never);
    int a_c, r_c, s_c, ila_at, h_at, h_fin, d;
    int e_aw, e_w, e_ila, e_hls, e_done, e_to, e_err, e_end;
    int n_aw, n_w, n_awhs, n_whs, n_ila, n_hls, n_done, n_to, n_err, n_busy;
    int c_done, c_to, c_err, rdy0, rdy_end;
    bit b_done;
    a_c = (aw_at > w_at) ? aw_at : w_at;
    if (a_c < 1) a_c = 1;
    r_c = (a_c + 1 > b_at) ? a_c + 1 : b_at;
    s_c = r_c + 1;
    e_aw = (aw_at < 1) ? 1 : aw_at;
    e_w  = (w_at < 1) ? 1 : w_at;
    ila_at = s_c + ila_off;
    h_at   = s_c + h_off;
    h_fin  = glitch ? h_at + 4 : h_at;
    e_done = -1; e_to = -1; e_err = -1;
    if (br != 2'b00) begin
      e_err = r_c; e_end = r_c + 1; e_ila = 0; e_hls = 0;
    end else begin
      d = never ? 100000 : (((h_fin + DRAIN) > (ila_at + 1)) ? h_fin + DRAIN : ila_at + 1) + 1;
      if (d > TMO_CYC) begin
        e_to = TMO_CYC; e_end = TMO_CYC + 1;
        e_ila = TMO_CYC + 1 - s_c; e_hls = TMO_CYC + 1 - s_c;
      end else begin
        e_done = d; e_end = d + 1;
        e_ila = ila_at - s_c; e_hls = h_fin + DRAIN - s_c;
      end
    end
    n_aw = 0; n_w = 0; n_awhs = 0; n_whs = 0; n_ila = 0; n_hls = 0;
    n_done = 0; n_to = 0; n_err = 0; n_busy = 0;
    c_done = -1; c_to = -1; c_err = -1; rdy0 = 0; rdy_end = 0; b_done = 0;
    for (int c = 0; c <= e_end; c++) begin
      exec_valid   = (c == 0) ? 1'b1 : ((c < e_end) ? 1'($urandom_range(0, 1)) : 1'b0);
      awready      = (c >= aw_at);
      wready       = (c >= w_at);
      bvalid       = (c >= b_at) && !b_done;
      bresp        = br;
      ila_complete = !never && (c >= ila_at);
      hls_complete = !never && (glitch ? (c >= h_at && c != h_at + 3) : (c >= h_at));
      @(negedge clk);
      if (c == 0) rdy0 = int'(exec_ready);
      if (c > 0 && c < e_end && exec_ready) n_busy++;
      if (c == e_end) rdy_end = int'(exec_ready);
      if (awvalid) n_aw++;
      if (wvalid) n_w++;
      if (awvalid && awready) n_awhs++;
      if (wvalid && wready) n_whs++;
      if (bvalid && bready) b_done = 1;
      if (ila_step) n_ila++;
      if (hls_step) n_hls++;
      if (done) begin n_done++; c_done = c; end
      if (timeout) begin n_to++; c_to = c; end
      if (cfg_err) begin n_err++; c_err = c; end
      @(posedge clk); #1;
    end
    drive_idle();
    check({name, ".ready_at_accept"}, rdy0, 1);
    check({name, ".ready_while_busy"}, n_busy, 0);
    check({name, ".ready_at_end"}, rdy_end, 1);
    check({name, ".awvalid_cycles"}, n_aw, e_aw);
    check({name, ".wvalid_cycles"}, n_w, e_w);
    check({name, ".aw_handshakes"}, n_awhs, 1);
    check({name, ".w_handshakes"}, n_whs, 1);
    check({name, ".ila_step_cycles"}, n_ila, e_ila);
    check({name, ".hls_step_cycles"}, n_hls, e_hls);
    check({name, ".done_count"}, n_done, (e_done >= 0) ? 1 : 0);
    check({name, ".done_cycle"}, c_done, e_done);
    check({name, ".timeout_count"}, n_to, (e_to >= 0) ? 1 : 0);
    check({name, ".timeout_cycle"}, c_to, e_to);
    check({name, ".cfg_err_count"}, n_err, (e_err >= 0) ? 1 : 0);
    check({name, ".cfg_err_cycle"}, c_err, e_err);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    #12;
    check("reset.exec_ready", int'(exec_ready), 1);
    check("reset.pulses", int'({done, timeout, cfg_err}), 0);
    check("reset.steps", int'({ila_step, hls_step}), 0);
    check("reset.axi_valids", int'({awvalid, wvalid, bready}), 0);
    check("reset.awaddr", int'(awaddr), 0);
    check("reset.wdata", int'(wdata), 1);
    check("reset.wstrb", int'(wstrb), 15);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_txn("basic",   0, 0, 2, 2'b00, 3, 5, 1'b0, 1'b0);
    run_txn("aw_late", 4, 1, 0, 2'b00, 0, 0, 1'b0, 1'b0);
    run_txn("bresp",   0, 0, 2, 2'b10, 0, 0, 1'b0, 1'b0);
    run_txn("glitch",  0, 0, 2, 2'b00, 1, 0, 1'b1, 1'b0);
    run_txn("both",    1, 2, 3, 2'b00, 2, 2, 1'b0, 1'b0);
    run_txn("hang",    0, 0, 2, 2'b00, 0, 0, 1'b0, 1'b1);

    // Reset in the middle of RUN.
    exec_valid = 1; awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
    @(posedge clk); #1; exec_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst.steps_before", int'({ila_step, hls_step}), 3);
    #2 rst = 1'b1;
    #1;
    check("midrst.steps_after", int'({ila_step, hls_step}), 0);
    check("midrst.exec_ready", int'(exec_ready), 1);
    check("midrst.axi", int'({awvalid, wvalid, bready}), 0);
    drive_idle();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_txn("post_rst", 0, 0, 2, 2'b00, 3, 5, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("rand%0d", i),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
              ($urandom_range(0, 5) == 0) ? 2'(1 + $urandom_range(0, 2)) : 2'b00,
              int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
